// File: rtl/peripheral_spram_wb_master.sv
// Wishbone B3 burst initiator: accepts one command at a time and runs a classic cycle or
// an incrementing/wrapping CTI/BTE burst, streaming write data in and read data out.
module peripheral_spram_wb_master #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [DW-1:0]   wdat_i,
  input  logic [DW/8-1:0] wsel_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [DW-1:0]   rdat_o,
  output logic            rvalid_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned OB = $clog2(BW);

  typedef enum logic [1:0] {IDLE, WDATA, BURST, DONE} state_t;

  state_t        state;
  logic          we_q;
  logic [1:0]    bte_q;
  logic          single_q;
  logic [LW-1:0] rem_q;

  logic          beat_ack;
  logic          beat_err;
  logic          more;
  logic [LW-1:0] rem_nxt;
  logic [AW-1:0] adr_inc;
  logic [AW-1:0] inc_mask;
  logic [AW-1:0] adr_nxt;

  function automatic logic [2:0] cti_of(input logic [LW-1:0] rem, input logic single);
    if (rem > LW'(1)) return 3'b010;
    return single ? 3'b000 : 3'b111;
  endfunction

  // Beat qualification and next-address generation; wrap bursts only carry within the beat-index field.
  always_comb begin
    beat_err = (state == BURST) && wb_stb_o && wb_err_i;
    beat_ack = (state == BURST) && wb_stb_o && wb_ack_i && !wb_err_i;
    more     = rem_q > LW'(1);
    rem_nxt  = rem_q - LW'(1);
    wready_o = (state == WDATA) || (beat_ack && we_q && more);
    adr_inc  = wb_adr_o + AW'(BW);
    case (bte_q)
      2'd1:    inc_mask = AW'(3) << OB;
      2'd2:    inc_mask = AW'(7) << OB;
      2'd3:    inc_mask = AW'(15) << OB;
      default: inc_mask = '1;
    endcase
    adr_nxt = (wb_adr_o & ~inc_mask) | (adr_inc & inc_mask);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      we_q        <= 1'b0;
      bte_q       <= 2'b00;
      single_q    <= 1'b0;
      rem_q       <= '0;
      rdat_o      <= '0;
      rvalid_o    <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cti_o    <= 3'b000;
      wb_bte_o    <= 2'b00;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            err_o       <= 1'b0;
            we_q        <= cmd_we_i;
            wb_we_o     <= cmd_we_i;
            bte_q       <= cmd_bte_i;
            wb_adr_o    <= cmd_adr_i;
            rem_q       <= (cmd_len_i == '0) ? LW'(1) : cmd_len_i;
            single_q    <= (cmd_len_i <= LW'(1));
            wb_cti_o    <= (cmd_len_i > LW'(1)) ? 3'b010 : 3'b000;
            wb_bte_o    <= (cmd_len_i > LW'(1)) ? cmd_bte_i : 2'b00;
            if (cmd_we_i) begin
              state <= WDATA;
            end else begin
              state    <= BURST;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= '1;
            end
          end
        end
        WDATA: begin
          if (wvalid_i) begin
            wb_dat_o <= wdat_i;
            wb_sel_o <= wsel_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat_err) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
            done_o   <= 1'b1;
            state    <= DONE;
          end else if (beat_ack) begin
            rem_q <= rem_nxt;
            if (!we_q) begin
              rdat_o   <= wb_dat_i;
              rvalid_o <= 1'b1;
            end
            if (!more) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              done_o   <= 1'b1;
              state    <= DONE;
            end else begin
              wb_adr_o <= adr_nxt;
              wb_cti_o <= cti_of(rem_nxt, single_q);
              // A write with no data ready pauses the strobe but keeps the bus cycle owned.
              if (we_q && !wvalid_i) begin
                wb_stb_o <= 1'b0;
                state    <= WDATA;
              end else if (we_q) begin
                wb_dat_o <= wdat_i;
                wb_sel_o <= wsel_i;
              end
            end
          end
        end
        DONE: begin
          cmd_ready_o <= 1'b1;
          err_o       <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/peripheral_spram_wb_master.md
Name: peripheral_spram_wb_master

Overview:
Wishbone B3 burst initiator that drives the SPRAM Wishbone slave and any other registered-feedback Wishbone slave in the MPSoC.
- Accepts one command at a time: address, beat count, direction and burst type.
- Issues a classic cycle or an incrementing/wrapping burst using CTI/BTE.
- Streams write data in and read data out.
- Used by DMA and test engines to fill and drain SPRAM.

Parameters:
- DW, 32, data width in bits; must be 32 or 64.
- AW, 32, byte address width.
- LW, 5, beat-count width; maximum burst length is 2^LW-1 beats.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  AW  start byte address, aligned to DW/8.
- cmd_len_i  in  LW  beat count; 0 is illegal and is treated as 1.
- cmd_bte_i  in  2  burst type: 0=linear, 1=wrap4, 2=wrap8, 3=wrap16.
- wdat_i  in  DW  write data.
- wsel_i  in  DW/8  write byte enables.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write beat taken when high with wvalid_i.
- rdat_o  out  DW  read data.
- rvalid_o  out  1  read beat valid, one-cycle pulse; no backpressure.
- done_o  out  1  one-cycle pulse at command completion.
- err_o  out  1  qualifies done_o; 1 = terminated by wb_err_i.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cti_o  out  3  Wishbone cycle type identifier.
- wb_bte_o  out  2  Wishbone burst type extension.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:

Reset:
- All outputs and the state machine are cleared asynchronously to 0 / IDLE.
- Exception: cmd_ready_o resets to 1.
- Reset asserted mid-burst drops cyc/stb immediately, does not pulse done_o, and discards the in-flight command.

State machine: IDLE, WDATA, BURST, DONE.

IDLE:
- cmd_ready_o=1.
- On cmd_valid_i: latch adr, we, bte and remaining=len (0 becomes 1); drop cmd_ready_o.
- Go to WDATA if write, else BURST.

WDATA:
- wready_o=1.
- On wvalid_i: load wb_dat_o/wb_sel_o, go to BURST.

BURST:
- cyc=stb=1.
- wb_we_o = latched we; wb_sel_o = all ones for reads.
- CTI rule:
  - remaining=1 with a single-beat command: 000.
  - remaining>1: 010.
  - remaining=1 on a multi-beat command: 111.
- wb_bte_o = latched bte for the whole cycle; 0 for classic cycles.

On wb_ack_i:
- remaining decrements.
- Address advances by DW/8 bytes:
  - linear: plain add.
  - wrap: only the low 2/3/4 beat-index bits above the byte offset increment modulo 4/8/16; upper bits are held.
- Read: rdat_o <= wb_dat_i and rvalid_o=1 the following cycle.
- Write, more beats remaining:
  - wready_o is high combinationally during ack.
  - If wvalid_i is also high, the next beat loads the same edge and stb stays high.
  - Otherwise stb drops (cyc stays high) and the block returns to WDATA.
  - On re-entry to BURST, CTI/address resume from the saved beat.
- Last ack (remaining becomes 0): cyc=stb=0 at the next edge; go to DONE.

wb_err_i in BURST:
- Takes priority over ack.
- Deassert cyc/stb next edge, no data beat is produced, go to DONE with err_o=1.

DONE:
- done_o=1 for one cycle; err_o valid in the same cycle.
- Then IDLE, with cmd_ready_o=1 the following cycle.

Other rules:
- Ack and err outside BURST, or while stb=0, are ignored.
- Address arithmetic wraps modulo 2^AW.
- Command inputs are sampled only at acceptance; later changes have no effect.

Test Plan:
1. Single read, adr=0x10, len=1, slave preloaded 0xCAFEF00D → CTI=000, BTE=00, one rvalid_o with rdat_o=0xCAFEF00D, done_o=1, err_o=0.
2. Linear write burst, adr=0x0, len=4, data 1..4, wvalid_i held high → adr 0x0/0x4/0x8/0xC; CTI 010,010,010,111; no stb gaps. A later read burst of 4 returns 1..4.
3. Wrap4 read, adr=0x8, len=4 → adr sequence 0x8, 0xC, 0x0, 0x4; BTE=01 throughout.
4. Write burst, len=3, wvalid_i low for 2 cycles after beat 1 → stb low with cyc high during the gap. Beat 2 is at adr+4 with CTI=010, beat 3 has CTI=111, memory is correct.
5. wb_err_i forced on beat 2 of a len=4 read → exactly 1 rvalid_o, cyc low next cycle, done_o with err_o=1.
6. wb_rst_i asserted mid-burst at beat 2 → cyc/stb/rvalid_o go to 0 asynchronously, no done_o pulse; after release cmd_ready_o=1 and a new len=2 command completes normally.
